// File: rtl/memory_stage.sv
// memory_stage: memory stage of a 5-stage RV64 pipeline.
//
// Runs a single-outstanding data-memory request/ack handshake for loads and
// stores and stalls IF/ID/EX while it is in flight. Store data is shifted
// into byte lanes with matching strobes. Load data is extracted from the
// 64-bit bus word and sign/zero extended. The block also drives the EX
// forwarding value and the MEM/WB pipeline register.
//
// Optional feature: define MEM_MISALIGN_CHECK_EN to flag accesses not aligned
// to their size. A flagged access issues no request, does not stall and
// retires with reg_we=0. When undefined, o_misalign is tied low and
// misaligned accesses simply use the lane shift. Bytes beyond lane 7 are lost.
//
// Ports:
//   i_clk, i_arst            clock (rising edge), async active-low reset
//   i_alu_result .. i_a0_reg_lsb   execute pipeline register outputs
//   o_dmem_* / i_dmem_*      data memory request/ack interface
//   o_stall_mem              stall request to IF/ID/EX
//   o_forward_value          EX forwarding value (combinational)
//   o_misalign               misaligned access flag
//   o_result_src .. o_a0_reg_lsb   MEM/WB pipeline register
module memory_stage #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic [ADDR_WIDTH-1:0] i_alu_result,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    input  logic [2:0]            i_func3,
    input  logic                  i_mem_access,
    input  logic                  i_mem_we,
    input  logic                  i_reg_we,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic [2:0]            i_result_src,
    input  logic [1:0]            i_forward_src,
    input  logic [ADDR_WIDTH-1:0] i_pc_plus4,
    input  logic [ADDR_WIDTH-1:0] i_pc_target,
    input  logic [DATA_WIDTH-1:0] i_imm_ext,
    input  logic                  i_ecall_instr,
    input  logic                  i_a0_reg_lsb,
    output logic                  o_dmem_req,
    output logic                  o_dmem_we,
    output logic [ADDR_WIDTH-1:0] o_dmem_addr,
    output logic [DATA_WIDTH-1:0] o_dmem_wdata,
    output logic [7:0]            o_dmem_wstrb,
    input  logic                  i_dmem_ack,
    input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
    output logic                  o_stall_mem,
    output logic [DATA_WIDTH-1:0] o_forward_value,
    output logic                  o_misalign,
    output logic [2:0]            o_result_src,
    output logic                  o_reg_we,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic [ADDR_WIDTH-1:0] o_alu_result,
    output logic [DATA_WIDTH-1:0] o_read_data,
    output logic [ADDR_WIDTH-1:0] o_pc_plus4,
    output logic [ADDR_WIDTH-1:0] o_pc_target,
    output logic [DATA_WIDTH-1:0] o_imm_ext,
    output logic                  o_ecall_instr,
    output logic                  o_a0_reg_lsb
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]            wstrb_q, wstrb_d;
    logic                  we_q, we_d;
    logic [2:0]            off_q, off_d;
    logic [2:0]            func3_q, func3_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [2:0]            off_in;
    logic                  misalign_in;
    logic [7:0]            strb_base;
    logic [DATA_WIDTH-1:0] load_shift;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [DATA_WIDTH-1:0] read_data_d;

    assign off_in = i_alu_result[2:0];

`ifdef MEM_MISALIGN_CHECK_EN
    always_comb begin
        misalign_in = 1'b0;
        case (i_func3[1:0])
            2'd1:    misalign_in = off_in[0];
            2'd2:    misalign_in = |off_in[1:0];
            2'd3:    misalign_in = |off_in;
            default: misalign_in = 1'b0;
        endcase
    end
`else
    assign misalign_in = 1'b0;
`endif

    always_comb begin
        strb_base = 8'h01;
        case (i_func3[1:0])
            2'd0:    strb_base = 8'h01;
            2'd1:    strb_base = 8'h03;
            2'd2:    strb_base = 8'h0F;
            default: strb_base = 8'hFF;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        we_d    = we_q;
        off_d   = off_q;
        func3_d = func3_q;
        rdata_d = rdata_q;
        case (state_q)
            StIdle: begin
                if (i_mem_access && !misalign_in) begin
                    state_d = StReq;
                    addr_d  = {i_alu_result[ADDR_WIDTH-1:3], 3'b000};
                    wdata_d = i_write_data << {off_in, 3'b000};
                    wstrb_d = strb_base << off_in;
                    we_d    = i_mem_we;
                    off_d   = off_in;
                    func3_d = i_func3;
                end
            end
            StReq: begin
                if (i_dmem_ack) begin
                    state_d = StDone;
                    if (!we_q) rdata_d = i_dmem_rdata;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Payload registers keep the last request; only req qualifies them.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            we_q    <= 1'b0;
            off_q   <= '0;
            func3_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            we_q    <= we_d;
            off_q   <= off_d;
            func3_q <= func3_d;
            rdata_q <= rdata_d;
        end
    end

    assign o_dmem_req   = (state_q == StReq);
    assign o_dmem_we    = we_q;
    assign o_dmem_addr  = addr_q;
    assign o_dmem_wdata = wdata_q;
    assign o_dmem_wstrb = wstrb_q;

    assign o_stall_mem = i_mem_access && !misalign_in && (state_q != StDone);
    assign o_misalign  = i_mem_access && misalign_in && (state_q == StIdle);

    assign load_shift = rdata_q >> {off_q, 3'b000};

    always_comb begin
        load_ext = '0;
        case (func3_q)
            3'd0:    load_ext = {{56{load_shift[7]}}, load_shift[7:0]};
            3'd1:    load_ext = {{48{load_shift[15]}}, load_shift[15:0]};
            3'd2:    load_ext = {{32{load_shift[31]}}, load_shift[31:0]};
            3'd3:    load_ext = load_shift;
            3'd4:    load_ext = {56'd0, load_shift[7:0]};
            3'd5:    load_ext = {48'd0, load_shift[15:0]};
            3'd6:    load_ext = {32'd0, load_shift[31:0]};
            default: load_ext = '0;
        endcase
    end

    // Only a load retiring from DONE returns memory data.
    assign read_data_d = (i_mem_access && !we_q && (state_q == StDone)) ? load_ext : '0;

    always_comb begin
        o_forward_value = i_alu_result;
        case (i_forward_src)
            2'd0:    o_forward_value = i_alu_result;
            2'd1:    o_forward_value = i_pc_target;
            2'd2:    o_forward_value = i_imm_ext;
            default: o_forward_value = i_pc_plus4;
        endcase
    end

    // MEM/WB register: a stalled cycle inserts an all-zero bubble.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            o_result_src  <= '0;
            o_reg_we      <= 1'b0;
            o_rd_addr     <= '0;
            o_alu_result  <= '0;
            o_read_data   <= '0;
            o_pc_plus4    <= '0;
            o_pc_target   <= '0;
            o_imm_ext     <= '0;
            o_ecall_instr <= 1'b0;
            o_a0_reg_lsb  <= 1'b0;
        end else if (o_stall_mem) begin
            o_result_src  <= '0;
            o_reg_we      <= 1'b0;
            o_rd_addr     <= '0;
            o_alu_result  <= '0;
            o_read_data   <= '0;
            o_pc_plus4    <= '0;
            o_pc_target   <= '0;
            o_imm_ext     <= '0;
            o_ecall_instr <= 1'b0;
            o_a0_reg_lsb  <= 1'b0;
        end else begin
            o_result_src  <= i_result_src;
            o_reg_we      <= i_reg_we && !o_misalign;
            o_rd_addr     <= i_rd_addr;
            o_alu_result  <= i_alu_result;
            o_read_data   <= read_data_d;
            o_pc_plus4    <= i_pc_plus4;
            o_pc_target   <= i_pc_target;
            o_imm_ext     <= i_imm_ext;
            o_ecall_instr <= i_ecall_instr;
            o_a0_reg_lsb  <= i_a0_reg_lsb;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: stimulus pushes expected writeback
// entries, a negedge monitor pops and compares whenever o_reg_we is high.
module tb_memory_stage;

    logic        i_clk = 1'b0;
    logic        i_arst;
    logic [63:0] i_alu_result, i_write_data, i_pc_plus4, i_pc_target, i_imm_ext;
    logic [2:0]  i_func3, i_result_src;
    logic        i_mem_access, i_mem_we, i_reg_we, i_ecall_instr, i_a0_reg_lsb;
    logic [4:0]  i_rd_addr;
    logic [1:0]  i_forward_src;
    logic        i_dmem_ack;
    logic [63:0] i_dmem_rdata;
    logic        o_dmem_req, o_dmem_we, o_stall_mem, o_misalign, o_reg_we;
    logic        o_ecall_instr, o_a0_reg_lsb;
    logic [63:0] o_dmem_addr, o_dmem_wdata, o_forward_value, o_alu_result, o_read_data;
    logic [63:0] o_pc_plus4, o_pc_target, o_imm_ext;
    logic [7:0]  o_dmem_wstrb;
    logic [2:0]  o_result_src;
    logic [4:0]  o_rd_addr;

    memory_stage dut (
        .i_clk(i_clk), .i_arst(i_arst),
        .i_alu_result(i_alu_result), .i_write_data(i_write_data), .i_func3(i_func3),
        .i_mem_access(i_mem_access), .i_mem_we(i_mem_we), .i_reg_we(i_reg_we),
        .i_rd_addr(i_rd_addr), .i_result_src(i_result_src), .i_forward_src(i_forward_src),
        .i_pc_plus4(i_pc_plus4), .i_pc_target(i_pc_target), .i_imm_ext(i_imm_ext),
        .i_ecall_instr(i_ecall_instr), .i_a0_reg_lsb(i_a0_reg_lsb),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_wdata(o_dmem_wdata), .o_dmem_wstrb(o_dmem_wstrb),
        .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
        .o_stall_mem(o_stall_mem), .o_forward_value(o_forward_value),
        .o_misalign(o_misalign), .o_result_src(o_result_src), .o_reg_we(o_reg_we),
        .o_rd_addr(o_rd_addr), .o_alu_result(o_alu_result), .o_read_data(o_read_data),
        .o_pc_plus4(o_pc_plus4), .o_pc_target(o_pc_target), .o_imm_ext(o_imm_ext),
        .o_ecall_instr(o_ecall_instr), .o_a0_reg_lsb(o_a0_reg_lsb)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] alu;
        logic [63:0] rdata;
        logic [2:0]  rsrc;
    } wb_t;

    wb_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Monitor: every retired register-writing instruction must match the queue head.
    always @(negedge i_clk) begin
        if (i_arst && o_reg_we) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", 64'd1, 64'd0);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("wb_rd", {59'd0, o_rd_addr}, {59'd0, e.rd});
                chk("wb_alu", o_alu_result, e.alu);
                chk("wb_read_data", o_read_data, e.rdata);
                chk("wb_result_src", {61'd0, o_result_src}, {61'd0, e.rsrc});
            end
        end
    end

    task automatic set_idle();
        i_mem_access = 1'b0; i_mem_we = 1'b0; i_reg_we = 1'b0; i_func3 = 3'd0;
        i_rd_addr = 5'd0; i_result_src = 3'd0; i_forward_src = 2'd0;
        i_alu_result = 64'd0; i_write_data = 64'd0;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic mem_op(input logic [63:0] addr, input logic [2:0] f3, input logic we,
                          input logic [63:0] wd, input logic [63:0] rdata, input int ack_cyc,
                          input logic [63:0] exp_rd, input int exp_stall,
                          input logic [63:0] exp_wdata, input logic [7:0] exp_strb,
                          input logic [4:0] rd);
        int  stalls;
        int  reqs;
        bit  done;
        wb_t e;
        i_mem_access = 1'b1; i_mem_we = we; i_reg_we = ~we; i_func3 = f3;
        i_alu_result = addr; i_write_data = wd; i_rd_addr = rd; i_result_src = 3'd1;
        if (!we) begin
            e.rd = rd; e.alu = addr; e.rdata = exp_rd; e.rsrc = 3'd1;
            exp_q.push_back(e);
        end
        stalls = 0; reqs = 0; done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            if (c == 0) chk("misalign_low", {63'd0, o_misalign}, 64'd0);
            if (!o_stall_mem) begin
                done = 1'b1;
                break;
            end
            stalls++;
            if (o_dmem_req) begin
                reqs++;
                if (reqs == 1) begin
                    chk("dmem_addr", o_dmem_addr, {addr[63:3], 3'b000});
                    chk("dmem_we", {63'd0, o_dmem_we}, {63'd0, we});
                    if (we) begin
                        chk("dmem_wdata", o_dmem_wdata, exp_wdata);
                        chk("dmem_wstrb", {56'd0, o_dmem_wstrb}, {56'd0, exp_strb});
                    end
                end
            end
            i_dmem_ack = (reqs == ack_cyc);
            i_dmem_rdata = rdata;
        end
        i_dmem_ack = 1'b0;
        if (!done) chk("mem_timeout", 64'd1, 64'd0);
        chk("stall_cycles", 64'(stalls), 64'(exp_stall));
        @(posedge i_clk); #1;
        set_idle();
    endtask

    task automatic nonmem(input logic [1:0] fsrc, input logic [63:0] exp_fwd,
                          input logic [4:0] rd, input logic [63:0] alu);
        wb_t e;
        i_mem_access = 1'b0; i_reg_we = 1'b1; i_forward_src = fsrc;
        i_rd_addr = rd; i_alu_result = alu; i_result_src = 3'd0;
        e.rd = rd; e.alu = alu; e.rdata = 64'd0; e.rsrc = 3'd0;
        exp_q.push_back(e);
        @(negedge i_clk);
        chk("forward_value", o_forward_value, exp_fwd);
        chk("nonmem_stall", {63'd0, o_stall_mem}, 64'd0);
        chk("nonmem_req", {63'd0, o_dmem_req}, 64'd0);
        @(posedge i_clk); #1;
        set_idle();
    endtask

    initial begin
        bit seen;
        i_arst = 1'b0; i_dmem_ack = 1'b0; i_dmem_rdata = 64'd0;
        i_pc_plus4 = 64'h2004; i_pc_target = 64'h3000; i_imm_ext = 64'h0000_0000_0000_0FF0;
        i_ecall_instr = 1'b0; i_a0_reg_lsb = 1'b0;
        set_idle();
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_req", {63'd0, o_dmem_req}, 64'd0);
        chk("rst_stall", {63'd0, o_stall_mem}, 64'd0);
        chk("rst_reg_we", {63'd0, o_reg_we}, 64'd0);
        chk("rst_read_data", o_read_data, 64'd0);
        chk("rst_misalign", {63'd0, o_misalign}, 64'd0);
        i_arst = 1'b1;
        @(posedge i_clk); #1;

        // ld, ack on the third REQ cycle
        mem_op(64'h1000, 3'd3, 1'b0, 64'd0, 64'h1122334455667788, 3,
               64'h1122334455667788, 4, 64'd0, 8'd0, 5'd1);
        mem_op(64'h1003, 3'd0, 1'b0, 64'd0, 64'h0000000080000000, 1,
               64'hFFFFFFFFFFFFFF80, 2, 64'd0, 8'd0, 5'd2);
        mem_op(64'h1003, 3'd4, 1'b0, 64'd0, 64'h0000000080000000, 2,
               64'h0000000000000080, 3, 64'd0, 8'd0, 5'd3);
        mem_op(64'h1002, 3'd1, 1'b0, 64'd0, 64'h0000000080010000, 1,
               64'hFFFFFFFFFFFF8001, 2, 64'd0, 8'd0, 5'd4);
        mem_op(64'h1004, 3'd6, 1'b0, 64'd0, 64'h89ABCDEF00000000, 1,
               64'h0000000089ABCDEF, 2, 64'd0, 8'd0, 5'd5);
        mem_op(64'h1000, 3'd7, 1'b0, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1,
               64'd0, 2, 64'd0, 8'd0, 5'd6);
        // stores
        mem_op(64'h1006, 3'd1, 1'b1, 64'h000000000000ABCD, 64'd0, 1,
               64'd0, 2, 64'hABCD000000000000, 8'hC0, 5'd0);
        mem_op(64'h1004, 3'd2, 1'b1, 64'h00000000CAFEBABE, 64'd0, 2,
               64'd0, 3, 64'hCAFEBABE00000000, 8'hF0, 5'd0);
        mem_op(64'h1001, 3'd0, 1'b1, 64'h000000000000005A, 64'd0, 1,
               64'd0, 2, 64'h0000000000005A00, 8'h02, 5'd0);

        // forwarding mux and non-memory passthrough
        nonmem(2'd3, 64'h2004, 5'd10, 64'h55);
        nonmem(2'd0, 64'h1234, 5'd11, 64'h1234);
        nonmem(2'd1, 64'h3000, 5'd12, 64'h99);
        nonmem(2'd2, 64'h0FF0, 5'd13, 64'h77);

`ifdef MEM_MISALIGN_CHECK_EN
        i_mem_access = 1'b1; i_mem_we = 1'b0; i_reg_we = 1'b1; i_func3 = 3'd2;
        i_alu_result = 64'h1002; i_rd_addr = 5'd7;
        @(negedge i_clk);
        chk("misalign_flag", {63'd0, o_misalign}, 64'd1);
        chk("misalign_req", {63'd0, o_dmem_req}, 64'd0);
        chk("misalign_stall", {63'd0, o_stall_mem}, 64'd0);
        @(posedge i_clk); #1;
        set_idle();
        @(negedge i_clk);
        chk("misalign_reg_we", {63'd0, o_reg_we}, 64'd0);
        @(posedge i_clk); #1;
`else
        // lane shift only: upper bytes fall off the word
        mem_op(64'h1002, 3'd2, 1'b0, 64'd0, 64'h0000DEADBEEF0000, 1,
               64'hFFFFFFFFDEADBEEF, 2, 64'd0, 8'd0, 5'd7);
        mem_op(64'h1004, 3'd3, 1'b1, 64'h1122334455667788, 64'd0, 1,
               64'd0, 2, 64'h5566778800000000, 8'hF0, 5'd0);
`endif

        // reset in the middle of a request
        i_mem_access = 1'b1; i_mem_we = 1'b0; i_reg_we = 1'b1; i_func3 = 3'd3;
        i_alu_result = 64'h1000; i_rd_addr = 5'd9;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            if (o_dmem_req) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_test_req_seen", {63'd0, seen}, 64'd1);
        i_arst = 1'b0;
        #1;
        chk("rst_mid_req_drop", {63'd0, o_dmem_req}, 64'd0);
        chk("rst_mid_reg_we", {63'd0, o_reg_we}, 64'd0);
        set_idle();
        @(negedge i_clk);
        i_arst = 1'b1;
        i_dmem_ack = 1'b1; i_dmem_rdata = 64'hDEADDEADDEADDEAD;
        for (int c = 0; c < 2; c++) begin
            @(negedge i_clk);
            chk("late_ack_req", {63'd0, o_dmem_req}, 64'd0);
            chk("late_ack_stall", {63'd0, o_stall_mem}, 64'd0);
        end
        i_dmem_ack = 1'b0;
        @(posedge i_clk); #1;
        // state is IDLE again: a fresh load runs the full handshake
        mem_op(64'h1008, 3'd5, 1'b0, 64'd0, 64'h000000000000F00D, 1,
               64'h000000000000F00D, 2, 64'd0, 8'd0, 5'd8);

        repeat (3) @(posedge i_clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
